// File: rtl/pix_pack12to16_if.sv
// pix_pack12to16 bus: FIFO read side, packed output handshake, flush control.
// master = packer side, slave = FIFO/consumer/control side.
interface pix_pack12to16_if;
    logic        fifo_rempty;
    logic [11:0] fifo_rd;
    logic        fifo_r;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        flush;
    logic        flush_done;
    logic        seq_err;

    modport master (
        input  fifo_rempty, fifo_rd, out_ready, flush,
        output fifo_r, out_valid, out_data, flush_done, seq_err
    );

    modport slave (
        output fifo_rempty, fifo_rd, out_ready, flush,
        input  fifo_r, out_valid, out_data, flush_done, seq_err
    );
endinterface

// File: rtl/pix_pack12to16.sv
// pix_pack12to16: packs 12-bit FIFO words LSB-first into 16-bit words.
// Optional macro SEQ_CHECK_EN adds a sticky +1 sequence checker on seq_err.
module pix_pack12to16 (
    input  logic                  clk,
    input  logic                  rst_,
    pix_pack12to16_if.master      bus
);
    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH_WAIT,
        S_FLUSH_PAD
    } state_t;

    state_t      r_state;
    logic        r_run;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic        r_flush_done;

    state_t      w_state_n;
    logic [31:0] w_acc_n;
    logic [5:0]  w_cnt_n;
    logic        w_ov_n;
    logic [15:0] w_od_n;
    logic        w_fd_n;
    logic        w_slot;
    logic        w_fifo_r;
    logic        w_pop;
    logic        w_emit;
    logic [15:0] w_mask;

    // Pop/emit decisions, accumulator update and flush sequencing.
    always_comb begin
        w_slot    = !r_out_valid || bus.out_ready;
        w_fifo_r  = r_run && (r_state != S_FLUSH_PAD) && (r_cnt <= 6'd20);
        w_pop     = w_fifo_r && !bus.fifo_rempty;
        w_emit    = (r_cnt >= 6'd16) && w_slot;
        w_mask    = ~(16'hFFFF << r_cnt[3:0]);
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_cnt_n   = r_cnt;
        w_ov_n    = r_out_valid && !bus.out_ready;
        w_od_n    = r_out_data;
        w_fd_n    = 1'b0;
        if (w_emit) begin
            w_acc_n = r_acc >> 16;
            w_cnt_n = r_cnt - 6'd16;
            w_ov_n  = 1'b1;
            w_od_n  = r_acc[15:0];
        end
        if (w_pop) begin
            w_acc_n = w_acc_n | ({20'd0, bus.fifo_rd} << w_cnt_n);
            w_cnt_n = w_cnt_n + 6'd12;
        end
        unique case (r_state)
            S_RUN: begin
                if (bus.flush) w_state_n = S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
                if (bus.fifo_rempty && (r_cnt < 6'd16)) begin
                    if (r_cnt == 6'd0) begin
                        w_state_n = S_RUN;
                        w_fd_n    = 1'b1;
                    end else begin
                        w_state_n = S_FLUSH_PAD;
                    end
                end
            end
            S_FLUSH_PAD: begin
                if (w_slot) begin
                    w_od_n    = r_acc[15:0] & w_mask;
                    w_ov_n    = 1'b1;
                    w_acc_n   = 32'd0;
                    w_cnt_n   = 6'd0;
                    w_fd_n    = 1'b1;
                    w_state_n = S_RUN;
                end
            end
            default: w_state_n = S_RUN;
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state      <= S_RUN;
            r_run        <= 1'b0;
            r_acc        <= 32'd0;
            r_cnt        <= 6'd0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 16'd0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_run        <= 1'b1;
            r_acc        <= w_acc_n;
            r_cnt        <= w_cnt_n;
            r_out_valid  <= w_ov_n;
            r_out_data   <= w_od_n;
            r_flush_done <= w_fd_n;
        end
    end

    assign bus.fifo_r     = w_fifo_r;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.flush_done = r_flush_done;

`ifdef SEQ_CHECK_EN
    logic [11:0] r_last12;
    logic        r_seq_first;
    logic        r_seq_err;

    // Each pop must be previous+1; first pop after reset/flush is the seed.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_last12    <= 12'd0;
            r_seq_first <= 1'b1;
            r_seq_err   <= 1'b0;
        end else if (w_pop) begin
            if (!r_seq_first && (bus.fifo_rd != r_last12 + 12'd1))
                r_seq_err <= 1'b1;
            r_last12    <= bus.fifo_rd;
            r_seq_first <= 1'b0;
        end else if (w_fd_n) begin
            r_seq_first <= 1'b1;
        end
    end

    assign bus.seq_err = r_seq_err;
`else
    assign bus.seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_pix_pack12to16.sv
// Bench for pix_pack12to16: FIFO model plus bit-queue reference.
// Output words are checked against a stream of popped bits, zero-padded at flush_done.
module tb_pix_pack12to16;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    pix_pack12to16_if bus();
    pix_pack12to16 dut (.clk(clk), .rst_(rst_), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] fq[$];
    bit          bitq[$];
    logic [15:0] got[$];
    bit          m_first = 1'b1;
    bit          m_err = 1'b0;
    logic [11:0] m_last = 12'd0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_d = 16'd0;

    task automatic drive_fifo();
        bus.fifo_rempty = (fq.size() == 0);
        bus.fifo_rd = (fq.size() == 0) ? 12'h000 : fq[0];
    endtask

    task automatic step();
        logic p, a;
        logic [15:0] d, e;
        logic [11:0] w;
        logic exp_se;
        @(negedge clk);
        p = bus.fifo_r && !bus.fifo_rempty;
        a = bus.out_valid && bus.out_ready;
        d = bus.out_data;
        if (prev_stall) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || d !== prev_d) begin
                n_bad++;
                $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                         bus.out_valid, d, prev_d);
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_d = d;
        @(posedge clk);
        #1;
        if (p) begin
            w = fq.pop_front();
            for (int i = 0; i < 12; i++) bitq.push_back(w[i]);
            if (!m_first && w !== m_last + 12'd1) m_err = 1'b1;
            m_last = w;
            m_first = 1'b0;
        end
        if (a) begin
            n_cmp++;
            if (bitq.size() < 16) begin
                n_bad++;
                $display("FAIL word: got extra word %h, required none (%0d bits left)",
                         d, bitq.size());
            end else begin
                e = 16'd0;
                for (int i = 0; i < 16; i++) e[i] = bitq.pop_front();
                if (d !== e) begin
                    n_bad++;
                    $display("FAIL word: got %h, required %h", d, e);
                end
                got.push_back(d);
            end
        end
        if (bus.flush_done === 1'b1) begin
            while (bitq.size() % 16 != 0) bitq.push_back(1'b0);
            m_first = 1'b1;
        end
`ifdef SEQ_CHECK_EN
        exp_se = m_err;
`else
        exp_se = m_err && 1'b0;
`endif
        n_cmp++;
        if (bus.seq_err !== exp_se) begin
            n_bad++;
            $display("FAIL seq_err: got %b, required %b", bus.seq_err, exp_se);
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.fifo_r, bus.flush_done, bus.seq_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctl: valid/fifo_r/done/err=%b, required 0000",
                     {bus.out_valid, bus.fifo_r, bus.flush_done, bus.seq_err});
        end
        n_cmp++;
        if (bus.out_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data: got %h, required 0000", bus.out_data);
        end
        fq.delete();
        bitq.delete();
        got.delete();
        m_first = 1'b1;
        m_err = 1'b0;
        prev_stall = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_fifo();
        repeat (2) @(posedge clk);
    endtask

    task automatic rel();
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        n_cmp++;
        if (bus.fifo_r !== 1'b0) begin
            n_bad++;
            $display("FAIL release_fifo_r: got %b, required 0", bus.fifo_r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush_and_wait(input int n, output int fd);
        fd = 0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        if (bus.flush_done === 1'b1) fd++;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.flush_done === 1'b1) fd++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        fq.push_back(12'h5A5);
        drive_fifo();
        rel();
        n_cmp++;
        if (bus.fifo_r !== 1'b1) begin
            n_bad++;
            $display("FAIL run_fifo_r: got %b, required 1", bus.fifo_r);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ex[3];
        ex[0] = 16'h2001;
        ex[1] = 16'h0300;
        ex[2] = 16'h0040;
        do_reset();
        for (int i = 1; i <= 4; i++) fq.push_back(12'(i));
        drive_fifo();
        rel();
        bus.out_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: valid=%b, required 0", bus.out_valid);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency: valid=%b, required 1", bus.out_valid);
        end
        repeat (9) step();
        n_cmp++;
        if (got.size() != 3) begin
            n_bad++;
            $display("FAIL basic_count: got %0d words, required 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== ex[i]) begin
                n_bad++;
                $display("FAIL basic_word%0d: got %h, required %h", i, got[i], ex[i]);
            end
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bitq.size() != 0) begin
            n_bad++;
            $display("FAIL basic_idle: valid=%b bits=%0d, required 0 and 0",
                     bus.out_valid, bitq.size());
        end
    endtask

    task automatic test_flush_empty();
        do_reset();
        rel();
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_cmp++;
        if (bus.flush_done !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_empty_e1: done=%b, required 0", bus.flush_done);
        end
        step();
        n_cmp++;
        if (bus.flush_done !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_empty_e2: done=%b, required 1", bus.flush_done);
        end
        step();
        n_cmp++;
        if (bus.flush_done !== 1'b0 || got.size() != 0) begin
            n_bad++;
            $display("FAIL flush_empty_e3: done=%b words=%0d, required 0 and 0",
                     bus.flush_done, got.size());
        end
    endtask

    task automatic test_flush_pad(input int nw);
        int fd;
        logic [15:0] ex[2];
        do_reset();
        fq.push_back(12'hABC);
        if (nw == 2) fq.push_back(12'h123);
        drive_fifo();
        rel();
        bus.out_ready = 1'b1;
        repeat (nw) step();
        flush_and_wait(20, fd);
        if (nw == 2) begin
            ex[0] = 16'h3ABC;
            ex[1] = 16'h0012;
        end else begin
            ex[0] = 16'h0ABC;
            ex[1] = 16'h0000;
        end
        n_cmp++;
        if (fd != 1 || got.size() != nw) begin
            n_bad++;
            $display("FAIL flush_pad%0d: done cycles=%0d words=%0d, required 1 and %0d",
                     nw, fd, got.size(), nw);
        end
        for (int i = 0; i < nw && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== ex[i]) begin
                n_bad++;
                $display("FAIL flush_pad%0d_word%0d: got %h, required %h",
                         nw, i, got[i], ex[i]);
            end
        end
    endtask

    task automatic test_seq();
        logic exp;
        do_reset();
        fq.push_back(12'h005);
        fq.push_back(12'h006);
        drive_fifo();
        rel();
        bus.out_ready = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (bus.seq_err !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_ok: got %b, required 0", bus.seq_err);
        end
        fq.push_back(12'h008);
        drive_fifo();
        repeat (8) step();
`ifdef SEQ_CHECK_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        n_cmp++;
        if (bus.seq_err !== exp) begin
            n_bad++;
            $display("FAIL seq_gap: got %b, required %b", bus.seq_err, exp);
        end
    endtask

    task automatic test_backpressure();
        int fd;
        logic [11:0] base;
        base = 12'($urandom);
        do_reset();
        for (int i = 0; i < 40; i++) fq.push_back(base + 12'(i));
        drive_fifo();
        rel();
        repeat (12) step();
        n_cmp++;
        if (bus.fifo_r !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall: fifo_r=%b valid=%b, required 0 and 1",
                     bus.fifo_r, bus.out_valid);
        end
        for (int i = 0; i < 80; i++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        bus.out_ready = 1'b1;
        flush_and_wait(60, fd);
        n_cmp++;
        if (got.size() != 30 || fq.size() != 0 || bitq.size() != 0 || fd != 1) begin
            n_bad++;
            $display("FAIL bp_total: words=%0d fifo=%0d bits=%0d done=%0d, required 30 0 0 1",
                     got.size(), fq.size(), bitq.size(), fd);
        end
    endtask

    task automatic test_reset_mid();
        int fd;
        do_reset();
        for (int i = 0; i < 5; i++) fq.push_back(12'($urandom) | 12'h801);
        drive_fifo();
        rel();
        repeat (4) step();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_prep: valid=%b, required 1", bus.out_valid);
        end
        #2;
        do_reset();
        fq.push_back(12'h111);
        fq.push_back(12'h222);
        drive_fifo();
        rel();
        bus.out_ready = 1'b1;
        flush_and_wait(20, fd);
        n_cmp++;
        if (got.size() != 2 || fd != 1) begin
            n_bad++;
            $display("FAIL mid_count: words=%0d done=%0d, required 2 and 1",
                     got.size(), fd);
        end else begin
            n_cmp++;
            if (got[0] !== 16'h2111 || got[1] !== 16'h0022) begin
                n_bad++;
                $display("FAIL mid_words: got %h %h, required 2111 0022",
                         got[0], got[1]);
            end
        end
    endtask

    task automatic test_random();
        int fd;
        do_reset();
        rel();
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && fq.size() < 6) fq.push_back(12'($urandom));
            drive_fifo();
            bus.flush = (c % 97 == 50) && (c < 350);
            step();
            bus.flush = 1'b0;
        end
        bus.out_ready = 1'b1;
        flush_and_wait(60, fd);
        n_cmp++;
        if (fq.size() != 0 || bitq.size() != 0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_drain: fifo=%0d bits=%0d valid=%b, required 0 0 0",
                     fq.size(), bitq.size(), bus.out_valid);
        end
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_fifo();
        test_reset();
        test_basic();
        test_flush_empty();
        test_flush_pad(1);
        test_flush_pad(2);
        test_seq();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
